// File: rtl/cpu_decode_if.sv
// Fetch/regfile/writeback-facing and execute-facing signals of the decode stage.
// The master modport is the surrounding pipeline; the slave modport is cpu_decode.
`ifndef TAG_SIZE
`define TAG_SIZE 4
`endif

interface cpu_decode_if;
  logic                 i_stall;
  logic                 o_stall;
  logic [`TAG_SIZE-1:0] i_tag;
  logic [31:0]          i_instruction;
  logic [31:0]          i_pc;
  logic [4:0]           o_rs1;
  logic [4:0]           o_rs2;
  logic [31:0]          i_rs1_data;
  logic [31:0]          i_rs2_data;
  logic                 i_wb_write;
  logic [4:0]           i_wb_rd;
  logic [31:0]          i_wb_rdata;
  logic [`TAG_SIZE-1:0] o_tag;
  logic [31:0]          o_pc;
  logic [31:0]          o_instruction;
  logic [4:0]           o_inst_rs1;
  logic [4:0]           o_inst_rs2;
  logic [4:0]           o_inst_rd;
  logic [31:0]          o_rs1_data;
  logic [31:0]          o_rs2_data;
  logic [31:0]          o_imm;
  logic                 o_is_load;

  modport master (
    output i_stall, i_tag, i_instruction, i_pc, i_rs1_data, i_rs2_data,
           i_wb_write, i_wb_rd, i_wb_rdata,
    input  o_stall, o_rs1, o_rs2, o_tag, o_pc, o_instruction,
           o_inst_rs1, o_inst_rs2, o_inst_rd, o_rs1_data, o_rs2_data,
           o_imm, o_is_load
  );

  modport slave (
    input  i_stall, i_tag, i_instruction, i_pc, i_rs1_data, i_rs2_data,
           i_wb_write, i_wb_rd, i_wb_rdata,
    output o_stall, o_rs1, o_rs2, o_tag, o_pc, o_instruction,
           o_inst_rs1, o_inst_rs2, o_inst_rd, o_rs1_data, o_rs2_data,
           o_imm, o_is_load
  );
endinterface

// File: rtl/cpu_decode.sv
// Decode stage: regfile read, immediate expansion, load-use interlock; CPU_DECODE_BYPASS_EN adds writeback bypass.
// Latency: 1 cycle from new tag to registered outputs, 2 when a load-use bubble is inserted.
// Backpressure: i_stall freezes everything; o_stall = i_stall || load-use hazard on the waiting instruction.
`ifndef TAG_SIZE
`define TAG_SIZE 4
`endif

module cpu_decode (
  input  logic        i_clock,
  input  logic        i_reset,
  cpu_decode_if.slave dec
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {ST_READY, ST_INTERLOCK} state_t;

  state_t               state, state_nxt;
  logic [`TAG_SIZE-1:0] last_tag;
  logic                 haz_mark;
  logic                 new_inst, hazard, issue;
  logic [31:0]          ins;
  logic [6:0]           opcode;
  logic [4:0]           rs1, rs2, rd;
  logic [31:0]          imm, rs1_val, rs2_val;

  assign ins    = dec.i_instruction;
  assign opcode = ins[6:0];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign rd     = ins[11:7];

  assign dec.o_rs1 = rs1;
  assign dec.o_rs2 = rs2;

  // haz_mark is only set by an issued load with rd != 0 and dropped on entering the bubble
  assign new_inst    = (dec.i_tag != last_tag);
  assign hazard      = (state == ST_READY) && haz_mark && new_inst &&
                       ((rs1 == dec.o_inst_rd) || (rs2 == dec.o_inst_rd));
  assign dec.o_stall = dec.i_stall || hazard;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_READY: begin
        if (!dec.i_stall && new_inst) begin
          if (hazard) state_nxt = ST_INTERLOCK;
          else        issue     = 1'b1;
        end
      end
      ST_INTERLOCK: begin
        if (!dec.i_stall) begin
          state_nxt = ST_READY;
          issue     = new_inst;
        end
      end
      default: state_nxt = ST_READY;
    endcase
  end

  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM:
        imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ins[31:12], 12'b0};
      OP_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    rs1_val = dec.i_rs1_data;
    rs2_val = dec.i_rs2_data;
`ifdef CPU_DECODE_BYPASS_EN
    if (dec.i_wb_write && (dec.i_wb_rd == rs1)) rs1_val = dec.i_wb_rdata;
    if (dec.i_wb_write && (dec.i_wb_rd == rs2)) rs2_val = dec.i_wb_rdata;
`endif
    // x0 wins over both regfile and bypass
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

`ifndef CPU_DECODE_BYPASS_EN
  logic unused_wb;
  assign unused_wb = &{1'b0, dec.i_wb_write, dec.i_wb_rd, dec.i_wb_rdata};
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_READY;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      haz_mark <= 1'b0;
    end else if (issue) begin
      haz_mark <= (opcode == OP_LOAD) && (rd != 5'd0);
    end else if ((state == ST_READY) && (state_nxt == ST_INTERLOCK)) begin
      haz_mark <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      last_tag          <= '0;
      dec.o_tag         <= '0;
      dec.o_pc          <= '0;
      dec.o_instruction <= '0;
      dec.o_inst_rs1    <= '0;
      dec.o_inst_rs2    <= '0;
      dec.o_inst_rd     <= '0;
      dec.o_rs1_data    <= '0;
      dec.o_rs2_data    <= '0;
      dec.o_imm         <= '0;
      dec.o_is_load     <= 1'b0;
    end else if (issue) begin
      last_tag          <= dec.i_tag;
      dec.o_tag         <= dec.i_tag;
      dec.o_pc          <= dec.i_pc;
      dec.o_instruction <= ins;
      dec.o_inst_rs1    <= rs1;
      dec.o_inst_rs2    <= rs2;
      dec.o_inst_rd     <= rd;
      dec.o_rs1_data    <= rs1_val;
      dec.o_rs2_data    <= rs2_val;
      dec.o_imm         <= imm;
      dec.o_is_load     <= (opcode == OP_LOAD);
    end
  end
endmodule

// File: tb/tb_cpu_decode.sv
// Bench for cpu_decode: directed cases followed by random traffic against a behavioural model.
`ifndef TAG_SIZE
`define TAG_SIZE 4
`endif

module tb_cpu_decode;
  localparam int TW = `TAG_SIZE;
  localparam int OPS [9] = '{3, 19, 103, 35, 99, 55, 23, 111, 51};

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clock = ~i_clock;

  cpu_decode_if bus ();
  cpu_decode u_dut (.i_clock(i_clock), .i_reset(i_reset), .dec(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: what execute should currently see, plus the pending load-use obligation
  logic [TW-1:0] m_last, m_tag;
  logic [31:0]   m_pc, m_ins, m_d1, m_d2;
  bit            m_haz;
  bit            exp_stall, obs_stall;

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic signed [31:0] s;
    s = $signed(w);
    case (w & 32'h7F)
      32'h03, 32'h13, 32'h67, 32'h73, 32'h0F: return 32'(s >>> 20);
      32'h23: return 32'((s >>> 25) << 5) | ((w >> 7) & 32'h1F);
      32'h63: return 32'((s >>> 31) << 12) | (((w >> 7) & 32'h1) << 11) |
                     (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      32'h37, 32'h17: return w & 32'hFFFFF000;
      32'h6F: return 32'((s >>> 31) << 20) | (w & 32'h000FF000) |
                     (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] fld(input logic [31:0] w, input int lsb);
    return 5'((w >> lsb) & 32'h1F);
  endfunction

  function automatic logic [31:0] ref_opnd(input logic [4:0] r, input logic [31:0] rf,
                                           input logic wbw, input logic [4:0] wbr,
                                           input logic [31:0] wbd);
    if (r == 5'd0) return 32'h0;
`ifdef CPU_DECODE_BYPASS_EN
    if (wbw && wbr == r) return wbd;
`else
    if (wbw && wbr == r && 1'b0) return wbd;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom();
    w[6:0]   = 7'(OPS[$urandom_range(0, 8)]);
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic model_reset();
    m_last = '0; m_tag = '0; m_pc = '0; m_ins = '0; m_d1 = '0; m_d2 = '0; m_haz = 0;
  endtask

  task automatic check_outputs();
    check("o_tag", 64'(bus.o_tag), 64'(m_tag));
    check("o_pc", 64'(bus.o_pc), 64'(m_pc));
    check("o_instruction", 64'(bus.o_instruction), 64'(m_ins));
    check("o_fields", 64'({bus.o_inst_rs1, bus.o_inst_rs2, bus.o_inst_rd}),
          64'({fld(m_ins, 15), fld(m_ins, 20), fld(m_ins, 7)}));
    check("o_rs1_data", 64'(bus.o_rs1_data), 64'(m_d1));
    check("o_rs2_data", 64'(bus.o_rs2_data), 64'(m_d2));
    check("o_imm", 64'(bus.o_imm), 64'(ref_imm(m_ins)));
    check("o_is_load", 64'(bus.o_is_load), 64'((m_ins & 32'h7F) == 32'h03));
  endtask

  // called at posedge+1 with inputs applied; returns at the next posedge+1
  task automatic tick();
    logic [4:0] r1, r2, prd;
    bit is_new, hz;
    r1 = fld(bus.i_instruction, 15);
    r2 = fld(bus.i_instruction, 20);
    prd = fld(m_ins, 7);
    is_new = (bus.i_tag != m_last);
    hz = m_haz && is_new && (r1 == prd || r2 == prd);
    exp_stall = bus.i_stall || hz;
    #3;
    obs_stall = bus.o_stall;
    check("o_stall", 64'(bus.o_stall), 64'(exp_stall));
    check("rf_addr", 64'({bus.o_rs1, bus.o_rs2}), 64'({r1, r2}));
    if (!bus.i_stall) begin
      if (hz) begin
        m_haz = 0;
      end else if (is_new) begin
        m_last = bus.i_tag;
        m_tag  = bus.i_tag;
        m_pc   = bus.i_pc;
        m_ins  = bus.i_instruction;
        m_d1   = ref_opnd(r1, bus.i_rs1_data, bus.i_wb_write, bus.i_wb_rd, bus.i_wb_rdata);
        m_d2   = ref_opnd(r2, bus.i_rs2_data, bus.i_wb_write, bus.i_wb_rd, bus.i_wb_rdata);
        m_haz  = ((m_ins & 32'h7F) == 32'h03) && (prd_of(m_ins) != 5'd0);
      end
    end
    @(posedge i_clock);
    #1;
    check_outputs();
  endtask

  function automatic logic [4:0] prd_of(input logic [31:0] w);
    return fld(w, 7);
  endfunction

  task automatic rand_side();
    bus.i_rs1_data = $urandom();
    bus.i_rs2_data = $urandom();
    bus.i_wb_write = 1'($urandom_range(0, 1));
    bus.i_wb_rd    = 5'($urandom_range(0, 3));
    bus.i_wb_rdata = $urandom();
  endtask

  task automatic present(input int tag, input logic [31:0] ins, input logic [31:0] pc);
    bus.i_tag = TW'(tag);
    bus.i_instruction = ins;
    bus.i_pc = pc;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_tag"}, 64'(bus.o_tag), 64'h0);
    check({pfx, "_pc_ins"}, {bus.o_pc, bus.o_instruction}, 64'h0);
    check({pfx, "_data"}, {bus.o_rs1_data, bus.o_rs2_data}, 64'h0);
    check({pfx, "_imm_flds"}, 64'({bus.o_imm, bus.o_inst_rs1, bus.o_inst_rs2,
                                   bus.o_inst_rd, bus.o_is_load}), 64'h0);
  endtask

  int f_tag;
  logic [31:0] f_pc;

  initial begin
    bus.i_stall = 1'b0;
    present(0, 32'h0, 32'h0);
    rand_side();
    bus.i_wb_write = 1'b0;
    model_reset();

    #12;
    check_all_zero("reset");
    check("reset_stall", 64'(bus.o_stall), 64'h0);
    @(posedge i_clock); #1;
    i_reset = 1'b1;

    // directed immediates
    present(1, 32'h00500093, 32'h0); tick();
    check("addi_tag", 64'(bus.o_tag), 64'd1);
    check("addi_rd", 64'(bus.o_inst_rd), 64'd1);
    check("addi_imm", 64'(bus.o_imm), 64'd5);
    check("addi_pc", 64'(bus.o_pc), 64'd0);
    present(2, 32'hFE000EE3, 32'h4); tick();
    check("beq_imm", 64'(bus.o_imm), 64'hFFFFFFFC);
    present(3, 32'h123452B7, 32'h8); tick();
    check("lui_imm", 64'(bus.o_imm), 64'h12345000);

    // load-use: exactly one stall cycle, issue two edges after arrival
    present(4, 32'h0000A103, 32'hC); tick();
    check("lw_is_load", 64'(bus.o_is_load), 64'd1);
    present(5, 32'h002101B3, 32'h10); tick();
    check("lu_stall_c1", 64'(obs_stall), 64'd1);
    check("lu_hold_tag", 64'(bus.o_tag), 64'd4);
    tick();
    check("lu_stall_c2", 64'(obs_stall), 64'd0);
    check("lu_issue_tag", 64'(bus.o_tag), 64'd5);

    // same-cycle writeback onto rs1
    present(6, 32'h000081B3, 32'h14);
    bus.i_rs1_data = 32'h11111111; bus.i_rs2_data = 32'h22222222;
    bus.i_wb_write = 1'b1; bus.i_wb_rd = 5'd1; bus.i_wb_rdata = 32'hDEADBEEF;
    tick();
`ifdef CPU_DECODE_BYPASS_EN
    check("bypass_rs1", 64'(bus.o_rs1_data), 64'hDEADBEEF);
`else
    check("bypass_rs1", 64'(bus.o_rs1_data), 64'h11111111);
`endif
    check("bypass_x0", 64'(bus.o_rs2_data), 64'h0);
    bus.i_wb_write = 1'b0;

    // stall freezes outputs while the tag moves on
    present(7, 32'h00700213, 32'h18); tick();
    bus.i_stall = 1'b1;
    present(8, 32'h00100293, 32'h1C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_frozen", 64'(bus.o_tag), 64'd7);
    end
    bus.i_stall = 1'b0;
    tick();
    check("stall_release", 64'(bus.o_tag), 64'd8);

    // reset while the bubble is in progress
    present(9, 32'h0000A103, 32'h20); tick();
    present(10, 32'h002101B3, 32'h24); tick();
    check("intlk_entered", 64'(obs_stall), 64'd1);
    i_reset = 1'b0;
    #1;
    check_all_zero("rst_intlk");
    check("rst_intlk_stall0", 64'(bus.o_stall), 64'h0);
    bus.i_stall = 1'b1;
    #1;
    check("rst_intlk_stall1", 64'(bus.o_stall), 64'h1);
    bus.i_stall = 1'b0;
    model_reset();
    @(posedge i_clock); #1;
    i_reset = 1'b1;

    // random traffic; fetch advances only when not stalled
    f_tag = 1; f_pc = 32'h100;
    present(f_tag, rand_ins(), f_pc);
    for (int c = 0; c < 600; c++) begin
      rand_side();
      bus.i_stall = ($urandom_range(0, 4) == 0);
      tick();
      if (!exp_stall && $urandom_range(0, 5) != 0) begin
        f_tag++;
        f_pc += 32'd4;
        present(f_tag, rand_ins(), f_pc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
